axi_lite_demux_n: RTL and testbench
===================================

# axi_lite_demux_n

AXI-Lite 1-to-NUM_SLAVES address-decoding router: one upstream AXI-Lite master port fans out to NUM_SLAVES downstream AXI-Lite slave ports. It replaces the fixed point-to-point master/slave hookup in the AXI-Lite subsystem. Independent read and write paths each allow one outstanding transaction. Unmapped addresses complete locally with DECERR.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8); strobe width STRB_W = DATA_WIDTH/8
- NUM_SLAVES, 4, downstream port count (1..16)
- BASE_ADDRS, {NUM_SLAVES{32'h0}}, flattened NUM_SLAVES*ADDR_WIDTH; slot i = base of slave i
- ADDR_MASKS, {NUM_SLAVES{32'h0}}, flattened; slave i hits when (addr & mask_i) == base_i
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1  upstream AW
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  DATA_WIDTH/STRB_W/1/1  upstream W
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  upstream B
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1  upstream AR
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  DATA_WIDTH/2/1/1  upstream R
- m_awaddr, m_wdata, m_wstrb, m_araddr  out  ADDR_WIDTH/DATA_WIDTH/STRB_W/ADDR_WIDTH  broadcast to all slaves
- m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready  out  NUM_SLAVES  per-slave, one-hot or zero
- m_awready, m_wready, m_arready, m_bvalid, m_rvalid  in  NUM_SLAVES  per-slave
- m_bresp  in  2*NUM_SLAVES;  m_rdata  in  DATA_WIDTH*NUM_SLAVES;  m_rresp  in  2*NUM_SLAVES

## Operation
- Decode: lowest index i with (addr & mask_i)==base_i wins; no hit -> error path.
- Write FSM W_IDLE, W_FWD, W_RESP, W_ERR:
  - W_IDLE: s_awready=1 until AW captured, s_wready=1 until W captured (independent; either order, same cycle allowed). When both held -> decode -> W_FWD (hit, sel latched) or W_ERR.
  - W_FWD: m_awvalid[sel], m_wvalid[sel] asserted from holding regs; each drops after own handshake; both done -> W_RESP.
  - W_RESP: s_bvalid=m_bvalid[sel], s_bresp=m_bresp[sel], m_bready[sel]=s_bready (combinational pass-through); handshake -> W_IDLE.
  - W_ERR: s_bvalid=1, s_bresp=2'b11 until s_bready -> W_IDLE. No downstream activity.
- Read FSM R_IDLE, R_FWD, R_DATA, R_ERR: R_IDLE s_arready=1, capture, decode; R_FWD m_arvalid[sel] until m_arready[sel]; R_DATA pass-through R from sel; R_ERR s_rvalid=1, s_rresp=2'b11, s_rdata=0 until s_rready.
- Slave responses (OKAY/SLVERR) forwarded unchanged. Read and write paths may target same or different slaves concurrently.

## Timing
- Reset: all s_*ready, s_bvalid, s_rvalid, all m_*valid, m_bready, m_rready = 0; s_bresp/s_rresp=0; s_rdata=0; m_* address/data = 0; FSMs to IDLE. s_awready/s_wready/s_arready rise the cycle after rst deasserts.
- Zero-wait slave: AW+W handshake cycle 0, m_awvalid/m_wvalid cycle 1, W_RESP cycle 2, B may return cycle 2. Read: AR cycle 0, m_arvalid cycle 1, R earliest cycle 2.
- Error: DECERR B/R valid in cycle 1 after capture.
- Valid, once asserted, holds with stable payload until handshake (AXI rule), both sides.
- Stray m_bvalid/m_rvalid from unselected slaves ignored (their ready held 0).
- Reset mid-transaction: aborts, outputs to reset values next edge; no response issued.

## Structure
- Package axi_lite_pkg: RESP_OKAY 2'b00, RESP_SLVERR 2'b10, RESP_DECERR 2'b11; write/read state enums.
- Sub-module axi_lite_addr_decode (combinational: addr -> sel index, hit), instantiated twice (AW, AR).
- Each FSM in its own always block; holding registers per channel.

## Test plan
- Write 0x1000_0004 data 0xDEADBEEF strb 0xF, slave1 base 0x1000_0000 mask 0xF000_0000 -> only m_awvalid[1]/m_wvalid[1] pulse, B OKAY passed back at cycle 2.
- Read unmapped 0xF000_0000 -> s_rvalid cycle 1, s_rresp=2'b11, s_rdata=0, no m_arvalid.
- W sent 3 cycles before AW -> W held, forwarded together with AW; correct slave receives data.
- Slave 2 holds m_awready low 5 cycles, s_bready low 4 cycles -> m_awvalid[2] and payload stable; s_bvalid stable; no new AW accepted.
- Concurrent read slave0 and write slave3 -> both complete independently, responses correct; overlapping regions -> lower index chosen.
- rst asserted in W_FWD -> next cycle all valids 0, FSM W_IDLE; following write completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared constants and state types for the AXI-Lite demux.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FWD,
    W_RESP,
    W_ERR
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FWD,
    R_DATA,
    R_ERR
  } r_state_e;

  // Width of a slave index; a single slave still gets a 1-bit index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational address decoder: lowest-index matching region wins.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = '0,
  localparam int SEL_W = sel_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SEL_W-1:0]      sel,
  output logic                  hit
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/axi_lite_demux_n.sv
// AXI-Lite 1-to-N address-decoding router, one outstanding read and write.
//
// state  | meaning
// W_IDLE | collecting AW and W into holding regs (either order)
// W_FWD  | presenting AW/W to the selected slave until each handshakes
// W_RESP | passing B back from the selected slave
// W_ERR  | local DECERR write response, no downstream traffic
// R_IDLE | accepting AR
// R_FWD  | presenting AR to the selected slave
// R_DATA | passing R back from the selected slave
// R_ERR  | local DECERR read response with zero data
module axi_lite_demux_n
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = '0,
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int SEL_W  = sel_width(NUM_SLAVES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            s_awaddr,
  input  logic                             s_awvalid,
  output logic                             s_awready,
  input  logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [STRB_W-1:0]                s_wstrb,
  input  logic                             s_wvalid,
  output logic                             s_wready,
  output logic [1:0]                       s_bresp,
  output logic                             s_bvalid,
  input  logic                             s_bready,
  input  logic [ADDR_WIDTH-1:0]            s_araddr,
  input  logic                             s_arvalid,
  output logic                             s_arready,
  output logic [DATA_WIDTH-1:0]            s_rdata,
  output logic [1:0]                       s_rresp,
  output logic                             s_rvalid,
  input  logic                             s_rready,
  output logic [ADDR_WIDTH-1:0]            m_awaddr,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic [STRB_W-1:0]                m_wstrb,
  output logic [ADDR_WIDTH-1:0]            m_araddr,
  output logic [NUM_SLAVES-1:0]            m_awvalid,
  output logic [NUM_SLAVES-1:0]            m_wvalid,
  output logic [NUM_SLAVES-1:0]            m_arvalid,
  output logic [NUM_SLAVES-1:0]            m_bready,
  output logic [NUM_SLAVES-1:0]            m_rready,
  input  logic [NUM_SLAVES-1:0]            m_awready,
  input  logic [NUM_SLAVES-1:0]            m_wready,
  input  logic [NUM_SLAVES-1:0]            m_arready,
  input  logic [NUM_SLAVES-1:0]            m_bvalid,
  input  logic [NUM_SLAVES-1:0]            m_rvalid,
  input  logic [2*NUM_SLAVES-1:0]          m_bresp,
  input  logic [DATA_WIDTH*NUM_SLAVES-1:0] m_rdata,
  input  logic [2*NUM_SLAVES-1:0]          m_rresp
);

  // Upstream readies stay low for the first cycle out of reset.
  logic rdy_en_q, rdy_en_d;

  w_state_e                w_state_q, w_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic [SEL_W-1:0]        wsel_q, wsel_d;

  r_state_e                r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [SEL_W-1:0]        rsel_q, rsel_d;

  logic [ADDR_WIDTH-1:0]   aw_dec_addr;
  logic [SEL_W-1:0]        aw_sel, ar_sel;
  logic                    aw_hit, ar_hit;

  // AW may already sit in the holding register when W completes the pair.
  assign aw_dec_addr = aw_held_q ? awaddr_q : s_awaddr;
  assign rdy_en_d    = 1'b1;

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_aw_decode (
    .addr (aw_dec_addr),
    .sel  (aw_sel),
    .hit  (aw_hit)
  );

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_ar_decode (
    .addr (s_araddr),
    .sel  (ar_sel),
    .hit  (ar_hit)
  );

  assign m_awaddr = awaddr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;
  assign m_araddr = araddr_q;

  // Write path: capture AW/W, forward to selected slave, return B.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wsel_d    = wsel_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    case (w_state_q)
      W_IDLE: begin
        s_awready = rdy_en_q & ~aw_held_q;
        s_wready  = rdy_en_q & ~w_held_q;
        if (s_awvalid && s_awready) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_awaddr;
        end
        if (s_wvalid && s_wready) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
        end
        if (aw_held_d && w_held_d) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (aw_hit) begin
            wsel_d    = aw_sel;
            w_state_d = W_FWD;
          end else begin
            w_state_d = W_ERR;
          end
        end
      end
      W_FWD: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (wsel_q == SEL_W'(i)) begin
            m_awvalid[i] = ~aw_done_q;
            m_wvalid[i]  = ~w_done_q;
            if (m_awvalid[i] && m_awready[i]) aw_done_d = 1'b1;
            if (m_wvalid[i] && m_wready[i])   w_done_d  = 1'b1;
          end
        end
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (wsel_q == SEL_W'(i)) begin
            s_bvalid    = m_bvalid[i];
            s_bresp     = m_bresp[2*i +: 2];
            m_bready[i] = s_bready;
          end
        end
        if (s_bvalid && s_bready) w_state_d = W_IDLE;
      end
      W_ERR: begin
        s_bvalid = 1'b1;
        s_bresp  = RESP_DECERR;
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read path: capture AR, forward to selected slave, return R.
  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rsel_d    = rsel_q;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rresp   = RESP_OKAY;
    s_rdata   = '0;
    m_arvalid = '0;
    m_rready  = '0;
    case (r_state_q)
      R_IDLE: begin
        s_arready = rdy_en_q;
        if (s_arvalid && s_arready) begin
          araddr_d = s_araddr;
          if (ar_hit) begin
            rsel_d    = ar_sel;
            r_state_d = R_FWD;
          end else begin
            r_state_d = R_ERR;
          end
        end
      end
      R_FWD: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (rsel_q == SEL_W'(i)) begin
            m_arvalid[i] = 1'b1;
            if (m_arready[i]) r_state_d = R_DATA;
          end
        end
      end
      R_DATA: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (rsel_q == SEL_W'(i)) begin
            s_rvalid    = m_rvalid[i];
            s_rdata     = m_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            s_rresp     = m_rresp[2*i +: 2];
            m_rready[i] = s_rready;
          end
        end
        if (s_rvalid && s_rready) r_state_d = R_IDLE;
      end
      R_ERR: begin
        s_rvalid = 1'b1;
        s_rresp  = RESP_DECERR;
        if (s_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and holding registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en_q  <= 1'b0;
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wsel_q    <= '0;
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      rsel_q    <= '0;
    end else begin
      rdy_en_q  <= rdy_en_d;
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wsel_q    <= wsel_d;
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      rsel_q    <= rsel_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_demux_n.sv
// Directed bench for axi_lite_demux_n; the bench plays all downstream slaves.
module tb_axi_lite_demux_n;
  import axi_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int SW = DW / 8;
  // slave0 0x0xxx_xxxx, slave1 0x1xxx_xxxx, slave2 0x2xxx_xxxx,
  // slave3 0x2xxx_xxxx or 0x3xxx_xxxx (overlaps slave2)
  localparam logic [NS*AW-1:0] BASES =
    {32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASKS =
    {32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     s_awaddr;
  logic              s_awvalid, s_awready;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic              s_wvalid, s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid, s_bready;
  logic [AW-1:0]     s_araddr;
  logic              s_arvalid, s_arready;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid, s_rready;
  logic [AW-1:0]     m_awaddr, m_araddr;
  logic [DW-1:0]     m_wdata;
  logic [SW-1:0]     m_wstrb;
  logic [NS-1:0]     m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
  logic [NS-1:0]     m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
  logic [2*NS-1:0]   m_bresp, m_rresp;
  logic [DW*NS-1:0]  m_rdata;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  axi_lite_demux_n #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_SLAVES (NS),
    .BASE_ADDRS (BASES),
    .ADDR_MASKS (MASKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .m_awaddr  (m_awaddr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_araddr  (m_araddr),
    .m_awvalid (m_awvalid),
    .m_wvalid  (m_wvalid),
    .m_arvalid (m_arvalid),
    .m_bready  (m_bready),
    .m_rready  (m_rready),
    .m_awready (m_awready),
    .m_wready  (m_wready),
    .m_arready (m_arready),
    .m_bvalid  (m_bvalid),
    .m_rvalid  (m_rvalid),
    .m_bresp   (m_bresp),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    m_awready = '0; m_wready = '0; m_arready = '0; m_bvalid = '0; m_rvalid = '0;
    m_bresp = '0; m_rdata = '0; m_rresp = '0;
    step(); step(); step();

    // reset values
    chk("rst_awready", s_awready, 0);
    chk("rst_wready",  s_wready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_bvalid",  s_bvalid, 0);
    chk("rst_rvalid",  s_rvalid, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_awaddr",  m_awaddr, 0);
    chk("rst_rdata",   s_rdata, 0);
    rst = 1'b0;
    #1;
    chk("rdy_low_at_release", s_awready, 0);
    step();
    chk("rdy_awready_up", s_awready, 1);
    chk("rdy_wready_up",  s_wready, 1);
    chk("rdy_arready_up", s_arready, 1);

    // zero-wait write to slave1
    m_awready = 4'hF; m_wready = 4'hF; m_arready = 4'hF;
    s_awvalid = 1'b1; s_awaddr = 32'h1000_0004;
    s_wvalid = 1'b1; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF;
    #1;
    chk("w1_awready", s_awready, 1);
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
    #1;
    chk("w1_awvalid_c1", m_awvalid, 4'b0010);
    chk("w1_wvalid_c1",  m_wvalid, 4'b0010);
    chk("w1_awaddr",     m_awaddr, 32'h1000_0004);
    chk("w1_wdata",      m_wdata, 32'hDEAD_BEEF);
    chk("w1_wstrb",      m_wstrb, 4'hF);
    chk("w1_awready_busy", s_awready, 0);
    step();
    m_bvalid = 4'b0010; m_bresp = 8'b00_00_00_00; s_bready = 1'b1;
    #1;
    chk("w1_awvalid_c2", m_awvalid, 0);
    chk("w1_bvalid",     s_bvalid, 1);
    chk("w1_bresp",      s_bresp, RESP_OKAY);
    chk("w1_bready",     m_bready, 4'b0010);
    step();
    m_bvalid = '0; s_bready = 1'b0;
    #1;
    chk("w1_bvalid_done", s_bvalid, 0);
    chk("w1_idle_ready",  s_awready, 1);

    // unmapped read, stray slave0 R ignored, s_rready held low one cycle
    s_arvalid = 1'b1; s_araddr = 32'hF000_0000;
    #1;
    chk("rerr_arready", s_arready, 1);
    step();
    s_arvalid = 1'b0;
    m_rvalid = 4'b0001; m_rdata[31:0] = 32'h1111_1111;
    #1;
    chk("rerr_rvalid",  s_rvalid, 1);
    chk("rerr_rresp",   s_rresp, RESP_DECERR);
    chk("rerr_rdata",   s_rdata, 0);
    chk("rerr_arvalid", m_arvalid, 0);
    chk("rerr_rready_m", m_rready, 0);
    step();
    chk("rerr_rvalid_hold", s_rvalid, 1);
    s_rready = 1'b1;
    step();
    s_rready = 1'b0; m_rvalid = '0; m_rdata = '0;
    #1;
    chk("rerr_done", s_rvalid, 0);
    chk("rerr_arready_back", s_arready, 1);

    // W three cycles ahead of AW, slave2 stalls AW five cycles and B held four
    m_awready = 4'h0;
    s_wvalid = 1'b1; s_wdata = 32'h1234_5678; s_wstrb = 4'h3;
    #1;
    chk("wfirst_wready", s_wready, 1);
    step();
    s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    #1;
    chk("wfirst_wready_held", s_wready, 0);
    chk("wfirst_no_fwd", m_wvalid, 0);
    chk("wfirst_awready", s_awready, 1);
    step(); step();
    s_awvalid = 1'b1; s_awaddr = 32'h2000_0010;
    step();
    s_awaddr = 32'h0000_0000;
    #1;
    chk("stall_awvalid_c1", m_awvalid, 4'b0100);
    chk("stall_wvalid_c1",  m_wvalid, 4'b0100);
    chk("stall_wdata",      m_wdata, 32'h1234_5678);
    chk("stall_wstrb",      m_wstrb, 4'h3);
    step();
    chk("stall_wvalid_done", m_wvalid, 0);
    for (int k = 0; k < 4; k++) begin
      chk("stall_awvalid", m_awvalid, 4'b0100);
      chk("stall_awaddr",  m_awaddr, 32'h2000_0010);
      chk("stall_no_new_aw", s_awready, 0);
      step();
    end
    s_awvalid = 1'b0; m_awready = 4'hF;
    #1;
    chk("stall_awvalid_c6", m_awvalid, 4'b0100);
    step();
    m_bvalid = 4'b0100; m_bresp[5:4] = RESP_SLVERR; s_bready = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("bhold_bvalid", s_bvalid, 1);
      chk("bhold_bresp",  s_bresp, RESP_SLVERR);
      chk("bhold_bready_m", m_bready, 0);
      step();
    end
    s_bready = 1'b1;
    #1;
    chk("bhold_bready_pass", m_bready, 4'b0100);
    step();
    m_bvalid = '0; m_bresp = '0; s_bready = 1'b0;
    #1;
    chk("bhold_done", s_bvalid, 0);
    chk("bhold_idle", s_awready, 1);

    // unmapped write
    s_awvalid = 1'b1; s_awaddr = 32'h4000_0000;
    s_wvalid = 1'b1; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    chk("werr_bvalid", s_bvalid, 1);
    chk("werr_bresp",  s_bresp, RESP_DECERR);
    chk("werr_awvalid", m_awvalid, 0);
    chk("werr_wvalid",  m_wvalid, 0);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    #1;
    chk("werr_done", s_bvalid, 0);

    // concurrent read slave0 and write slave3, with stray responses
    s_arvalid = 1'b1; s_araddr = 32'h0000_0100;
    s_awvalid = 1'b1; s_awaddr = 32'h3000_0000;
    s_wvalid = 1'b1; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
    step();
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    chk("cc_arvalid", m_arvalid, 4'b0001);
    chk("cc_araddr",  m_araddr, 32'h0000_0100);
    chk("cc_awvalid", m_awvalid, 4'b1000);
    chk("cc_wvalid",  m_wvalid, 4'b1000);
    chk("cc_wdata",   m_wdata, 32'hCAFE_F00D);
    step();
    m_rvalid = 4'b0101; m_rdata[31:0] = 32'hA5A5_0001; m_rdata[95:64] = 32'hBAD0_BAD0;
    m_rresp = 8'b00_10_00_00;
    m_bvalid = 4'b1001; m_bresp = 8'b00_00_00_01;
    s_rready = 1'b1; s_bready = 1'b1;
    #1;
    chk("cc_rvalid",  s_rvalid, 1);
    chk("cc_rdata",   s_rdata, 32'hA5A5_0001);
    chk("cc_rresp",   s_rresp, RESP_OKAY);
    chk("cc_rready_m", m_rready, 4'b0001);
    chk("cc_bvalid",  s_bvalid, 1);
    chk("cc_bresp",   s_bresp, RESP_OKAY);
    chk("cc_bready_m", m_bready, 4'b1000);
    step();
    m_rvalid = '0; m_bvalid = '0; m_rdata = '0; m_rresp = '0; m_bresp = '0;
    s_rready = 1'b0; s_bready = 1'b0;
    #1;
    chk("cc_rdone", s_rvalid, 0);
    chk("cc_bdone", s_bvalid, 0);

    // overlap: 0x2xxx hits slave2 and slave3, slave2 chosen
    s_arvalid = 1'b1; s_araddr = 32'h2000_0040;
    step();
    s_arvalid = 1'b0;
    #1;
    chk("ovl_arvalid", m_arvalid, 4'b0100);
    step();
    m_rvalid = 4'b0100; m_rdata[95:64] = 32'h2222_0000; m_rresp[5:4] = RESP_SLVERR;
    s_rready = 1'b1;
    #1;
    chk("ovl_rdata", s_rdata, 32'h2222_0000);
    chk("ovl_rresp", s_rresp, RESP_SLVERR);
    step();
    m_rvalid = '0; m_rdata = '0; m_rresp = '0; s_rready = 1'b0;

    // reset while in W_FWD, then a normal write
    m_awready = 4'h0;
    s_awvalid = 1'b1; s_awaddr = 32'h1000_0008;
    s_wvalid = 1'b1; s_wdata = 32'h7777_7777; s_wstrb = 4'hF;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    chk("rfwd_awvalid", m_awvalid, 4'b0010);
    rst = 1'b1;
    step();
    chk("rfwd_awvalid_rst", m_awvalid, 0);
    chk("rfwd_wvalid_rst",  m_wvalid, 0);
    chk("rfwd_awaddr_rst",  m_awaddr, 0);
    chk("rfwd_awready_rst", s_awready, 0);
    rst = 1'b0;
    m_awready = 4'hF;
    #1;
    chk("rfwd_awready_rel", s_awready, 0);
    step();
    chk("rfwd_awready_up", s_awready, 1);
    chk("rfwd_no_bvalid",  s_bvalid, 0);
    chk("rfwd_no_awvalid", m_awvalid, 0);
    s_awvalid = 1'b1; s_awaddr = 32'h1000_000C;
    s_wvalid = 1'b1; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hC;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    chk("post_awvalid", m_awvalid, 4'b0010);
    chk("post_awaddr",  m_awaddr, 32'h1000_000C);
    chk("post_wdata",   m_wdata, 32'h0BAD_F00D);
    chk("post_wstrb",   m_wstrb, 4'hC);
    step();
    m_bvalid = 4'b0010; s_bready = 1'b1;
    #1;
    chk("post_bvalid", s_bvalid, 1);
    chk("post_bresp",  s_bresp, RESP_OKAY);
    step();
    m_bvalid = '0; s_bready = 1'b0;
    #1;
    chk("post_done", s_bvalid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
